// File: rtl/i2c_reg_bank.sv
// Register bank shared by the I2C slave controller and local control logic.
// A round-robin arbiter serializes the two ports; each access takes IDLE -> ACCESS -> RESP.
module i2c_reg_bank #(
    parameter int         NUM_REGS = 32,
    parameter logic [6:0] DEV_ID   = 7'h2A,
    parameter logic [7:0] ID_ADDR  = 8'h14
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        i2c_req,
    input  logic        i2c_rnw,
    input  logic [7:0]  i2c_addr,
    input  logic [15:0] i2c_wr_data,
    output logic [15:0] i2c_rd_data,
    output logic        i2c_ack,
    input  logic        loc_req,
    input  logic        loc_rnw,
    input  logic [7:0]  loc_addr,
    input  logic [15:0] loc_wr_data,
    output logic [15:0] loc_rd_data,
    output logic        loc_ack,
    output logic        err
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic PORT_I2C = 1'b0;
    localparam logic PORT_LOC = 1'b1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_reg;
    logic        grant_reg;
    logic        last_grant_reg;
    logic        rnw_reg;
    logic [7:0]  addr_reg;
    logic [15:0] wdata_reg;
    logic [15:0] data_reg;
    logic        err_flag_reg;
    logic [15:0] regs_reg [NUM_REGS];

    logic pick_loc;
    logic in_range;
    logic id_block;
    logic wr_en;

    // Local wins only when I2C is idle or I2C was the last port served.
    assign pick_loc = loc_req && (!i2c_req || (last_grant_reg == PORT_I2C));
    assign in_range = ({1'b0, addr_reg} < 9'(NUM_REGS));
    assign id_block = (grant_reg == PORT_I2C) && (addr_reg == ID_ADDR);
    assign wr_en    = (state_reg == ACCESS) && !rnw_reg && in_range && !id_block;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= (i == int'(ID_ADDR)) ? {9'b0, DEV_ID} : 16'h0000;
            end
        end else if (wr_en) begin
            regs_reg[addr_reg[AW-1:0]] <= wdata_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg      <= IDLE;
            grant_reg      <= PORT_I2C;
            last_grant_reg <= PORT_LOC;
            rnw_reg        <= 1'b0;
            addr_reg       <= 8'h00;
            wdata_reg      <= 16'h0000;
            data_reg       <= 16'h0000;
            err_flag_reg   <= 1'b0;
            i2c_rd_data    <= 16'h0000;
            i2c_ack        <= 1'b0;
            loc_rd_data    <= 16'h0000;
            loc_ack        <= 1'b0;
            err            <= 1'b0;
        end else begin
            i2c_ack <= 1'b0;
            loc_ack <= 1'b0;
            err     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i2c_req || loc_req) begin
                        grant_reg      <= pick_loc;
                        last_grant_reg <= pick_loc;
                        rnw_reg        <= pick_loc ? loc_rnw     : i2c_rnw;
                        addr_reg       <= pick_loc ? loc_addr    : i2c_addr;
                        wdata_reg      <= pick_loc ? loc_wr_data : i2c_wr_data;
                        state_reg      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (rnw_reg) begin
                        data_reg <= in_range ? regs_reg[addr_reg[AW-1:0]] : 16'h0000;
                    end
                    err_flag_reg <= !in_range || (!rnw_reg && id_block);
                    state_reg    <= RESP;
                end
                RESP: begin
                    if (grant_reg == PORT_LOC) begin
                        loc_ack <= 1'b1;
                        if (rnw_reg) loc_rd_data <= data_reg;
                    end else begin
                        i2c_ack <= 1'b1;
                        if (rnw_reg) i2c_rd_data <= data_reg;
                    end
                    err       <= err_flag_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: directed table, hand-written corner sequences,
// and random accesses scored against a simple array model of the register map.
module tb_i2c_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        i2c_req, i2c_rnw;
    logic [7:0]  i2c_addr;
    logic [15:0] i2c_wr_data, i2c_rd_data;
    logic        i2c_ack;
    logic        loc_req, loc_rnw;
    logic [7:0]  loc_addr;
    logic [15:0] loc_wr_data, loc_rd_data;
    logic        loc_ack;
    logic        err;

    always #5 clk = ~clk;

    i2c_reg_bank dut (
        .CLK         (clk),
        .Reset       (rst),
        .i2c_req     (i2c_req),
        .i2c_rnw     (i2c_rnw),
        .i2c_addr    (i2c_addr),
        .i2c_wr_data (i2c_wr_data),
        .i2c_rd_data (i2c_rd_data),
        .i2c_ack     (i2c_ack),
        .loc_req     (loc_req),
        .loc_rnw     (loc_rnw),
        .loc_addr    (loc_addr),
        .loc_wr_data (loc_wr_data),
        .loc_rd_data (loc_rd_data),
        .loc_ack     (loc_ack),
        .err         (err)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_m [32];
    logic [15:0] last_rd_m [2];

    typedef struct {
        bit          port;   // 0 = I2C, 1 = local
        bit          rnw;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = 16'h0000;
        mem_m[20] = 16'h002A;
        last_rd_m[0] = 16'h0000;
        last_rd_m[1] = 16'h0000;
    endtask

    task automatic model_access(input bit port, input bit rnw, input logic [7:0] addr,
                                input logic [15:0] wd, output logic [15:0] exp_rd,
                                output bit exp_err);
        exp_err = (addr >= 8'd32) || (!rnw && !port && addr == 8'h14);
        if (rnw) last_rd_m[port] = (addr < 8'd32) ? mem_m[addr[4:0]] : 16'h0000;
        else if (!exp_err) mem_m[addr[4:0]] = wd;
        exp_rd = last_rd_m[port];
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        i2c_req = 1'b0;
        loc_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_access(input string tag, input bit port, input bit rnw,
                             input logic [7:0] addr, input logic [15:0] wd,
                             input logic [15:0] exp_rd, input bit exp_err);
        logic [15:0] other_before;
        int n;
        bit seen;
        other_before = port ? i2c_rd_data : loc_rd_data;
        @(negedge clk);
        if (port) begin
            loc_rnw = rnw; loc_addr = addr; loc_wr_data = wd; loc_req = 1'b1;
        end else begin
            i2c_rnw = rnw; i2c_addr = addr; i2c_wr_data = wd; i2c_req = 1'b1;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (i2c_ack || loc_ack) seen = 1'b1;
        end
        i2c_req = 1'b0;
        loc_req = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no ack expected ack within 8 cycles", tag);
            return;
        end
        $display("txn %s port=%0d rnw=%0d addr=%h wd=%h rd=%h err=%0d", tag, port, rnw,
                 addr, wd, port ? loc_rd_data : i2c_rd_data, err);
        check({tag, " latency"}, n, 3);
        check({tag, " ack_port"}, {i2c_ack, loc_ack}, port ? 2'b01 : 2'b10);
        check({tag, " rd_data"}, port ? loc_rd_data : i2c_rd_data, exp_rd);
        check({tag, " err"}, err, exp_err);
        check({tag, " other_rd_hold"}, port ? i2c_rd_data : loc_rd_data, other_before);
    endtask

    vec_t vecs [14];

    initial begin
        logic [15:0] e_rd;
        bit          e_err;
        int          n;
        bit          seen;

        rst = 1'b1;
        i2c_req = 1'b0; i2c_rnw = 1'b0; i2c_addr = 8'h00; i2c_wr_data = 16'h0000;
        loc_req = 1'b0; loc_rnw = 1'b0; loc_addr = 8'h00; loc_wr_data = 16'h0000;

        // Reset ID read: I2C already polling the ID when reset releases.
        @(negedge clk);
        i2c_req = 1'b1; i2c_rnw = 1'b1; i2c_addr = 8'h14;
        repeat (2) @(negedge clk);
        check("reset outputs", {i2c_rd_data, i2c_ack, loc_rd_data, loc_ack, err}, 35'h0);
        rst = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (i2c_ack) seen = 1'b1;
        end
        i2c_req = 1'b0;
        $display("txn reset_id rd=%h err=%0d cycles=%0d", i2c_rd_data, err, n);
        check("reset_id latency", n, 3);
        check("reset_id rd_data", i2c_rd_data, 16'h002A);
        check("reset_id err", err, 1'b0);

        // Contention: both ports request continuously straight out of reset.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        i2c_req = 1'b1; i2c_rnw = 1'b1; i2c_addr = 8'h05;
        loc_req = 1'b1; loc_rnw = 1'b1; loc_addr = 8'h14;
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            $display("txn contention cycle=%0d i2c_ack=%0d loc_ack=%0d", k, i2c_ack, loc_ack);
            check($sformatf("contention acks cycle %0d", k), {i2c_ack, loc_ack},
                  (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 1) ? 2'b10 : 2'b01));
        end
        i2c_req = 1'b0;
        loc_req = 1'b0;
        check("contention loc_rd_data", loc_rd_data, 16'h002A);
        check("contention i2c_rd_data", i2c_rd_data, 16'h0000);

        // Directed table.
        vecs[0]  = '{1'b1, 1'b0, 8'h05, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h05, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h14, 16'h1234, 16'hBEEF, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h14, 16'h0000, 16'h002A, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h40, 16'h0000, 16'h0000, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'h14, 16'h0033, 16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'h14, 16'h0000, 16'h0033, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h14, 16'h0000, 16'h0033, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h1F, 16'hFFFF, 16'h0033, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'h1F, 16'h0000, 16'hFFFF, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'h20, 16'h5555, 16'hFFFF, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'h20, 16'h0000, 16'h0000, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 16'h1111, 16'h0033, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'h00, 16'h0000, 16'h1111, 1'b0};
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            model_access(vecs[i].port, vecs[i].rnw, vecs[i].addr, vecs[i].wd, e_rd, e_err);
            do_access($sformatf("vec%0d", i), vecs[i].port, vecs[i].rnw, vecs[i].addr,
                      vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err);
        end

        // Random accesses against the model.
        for (int i = 0; i < 60; i++) begin
            bit          p, r;
            logic [7:0]  a;
            logic [15:0] w;
            int          sel;
            p   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            if (sel == 0)      a = 8'h14;
            else if (sel == 1) a = 8'($urandom_range(32, 255));
            else               a = 8'($urandom_range(0, 31));
            w = 16'($urandom);
            model_access(p, r, a, w, e_rd, e_err);
            do_access($sformatf("rnd%0d", i), p, r, a, w, e_rd, e_err);
        end

        // Reset during the ACCESS cycle of a local write.
        model_access(1'b1, 1'b0, 8'h14, 16'h0033, e_rd, e_err);
        do_access("id_overwrite", 1'b1, 1'b0, 8'h14, 16'h0033, e_rd, e_err);
        @(negedge clk);
        loc_rnw = 1'b0; loc_addr = 8'h07; loc_wr_data = 16'hAAAA; loc_req = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        loc_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort no ack %0d", k), {i2c_ack, loc_ack, err}, 3'b000);
        end
        $display("txn abort loc write addr=07 ack=%0d", loc_ack);
        rst = 1'b0;
        model_reset();
        do_access("abort_rd07", 1'b0, 1'b1, 8'h07, 16'h0000, 16'h0000, 1'b0);
        do_access("abort_rd14", 1'b0, 1'b1, 8'h14, 16'h0000, 16'h002A, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
